// File: rtl/ram_io_responder.sv
// Responder for the byte-serial RAM port: main RAM with a one-cycle read,
// a memory-mapped TX FIFO / RX byte path, and a sticky simulation-halt flag.
module ram_io_responder #(
    parameter int          ADDR_WIDTH   = 17,
    parameter logic [31:0] IO_PORT_ADDR = 32'h0003_0000,
    parameter logic [31:0] IO_HALT_ADDR = 32'h0003_0004,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        wr_en_in,
    input  logic [31:0] addr_in,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        io_buffer_full,
    output logic [7:0]  io_tx_data,
    output logic        io_tx_valid,
    input  logic        io_tx_ready,
    input  logic [7:0]  io_rx_data,
    input  logic        io_rx_valid,
    output logic        io_rx_ack,
    output logic        sim_end,
    output logic        tx_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0] mem [2**ADDR_WIDTH];
    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count, next_count;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  is_io, is_halt, is_ram;
    logic                  io_wr, push, pop, drop;

    always_comb begin
        is_io   = (addr_in == IO_PORT_ADDR);
        is_halt = (addr_in == IO_HALT_ADDR);
        is_ram  = !is_io && !is_halt;
        ram_idx = addr_in[ADDR_WIDTH-1:0];

        pop   = rdy_in && (count != '0) && io_tx_ready;
        io_wr = rdy_in && wr_en_in && is_io;
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        push  = io_wr && ((count < CNT_W'(FIFO_DEPTH)) || pop);
        drop  = io_wr && !push;

        next_count = count;
        if (push && !pop)
            next_count = count + CNT_W'(1);
        else if (pop && !push)
            next_count = count - CNT_W'(1);
    end

    assign io_tx_data  = fifo_mem[rd_ptr];
    assign io_tx_valid = (count != '0);

    // Storage arrays are not reset; only the pointers define FIFO contents.
    always_ff @(posedge clk_in) begin
        if (rdy_in && wr_en_in && is_ram)
            mem[ram_idx] <= data_in;
        if (push)
            fifo_mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_out       <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
            io_rx_ack      <= 1'b0;
            sim_end        <= 1'b0;
            tx_overflow    <= 1'b0;
        end else if (rdy_in) begin
            io_rx_ack <= 1'b0;
            if (!wr_en_in) begin
                if (is_ram) begin
                    data_out <= mem[ram_idx];
                end else if (is_io && io_rx_valid) begin
                    data_out  <= io_rx_data;
                    io_rx_ack <= 1'b1;
                end else begin
                    data_out <= '0;
                end
            end
            if (wr_en_in && is_halt)
                sim_end <= 1'b1;
            if (drop)
                tx_overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= next_count;
            // One entry of margin absorbs the controller's one-cycle reaction delay.
            io_buffer_full <= (next_count >= CNT_W'(FIFO_DEPTH - 1));
        end else begin
            io_rx_ack <= 1'b0;
        end
    end

endmodule

// File: doc/ram_io_responder.md
Name: ram_io_responder

Overview:
- Responder end of the byte-serial RAM port driven by the memory controller: one address, one R/W flag and one data byte per cycle.
- Holds the byte-addressable main RAM with one-cycle registered read latency.
- Decodes the memory-mapped I/O port into a TX FIFO toward the UART/host side, with an RX byte path for I/O reads.
- Generates io_buffer_full, the backpressure signal the controller holds on while it is performing an I/O access.

Parameters:
- ADDR_WIDTH, 17, RAM index width; RAM holds 2^ADDR_WIDTH bytes.
- IO_PORT_ADDR, 32'h00030000, byte I/O data port.
- IO_HALT_ADDR, 32'h00030004, simulation-end port.
- FIFO_DEPTH, 8, TX FIFO entries (power of two, at least 4).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous active-high reset.
- rdy_in  in  1  global enable; 0 freezes all state.
- wr_en_in  in  1  1 = write, 0 = read.
- addr_in  in  32  byte address.
- data_in  in  8  write byte.
- data_out  out  8  read byte, registered.
- io_buffer_full  out  1  TX FIFO nearly full.
- io_tx_data  out  8  FIFO head byte.
- io_tx_valid  out  1  FIFO non-empty.
- io_tx_ready  in  1  sink accepts head byte.
- io_rx_data  in  8  incoming byte.
- io_rx_valid  in  1  incoming byte present.
- io_rx_ack  out  1  one-cycle pulse: RX byte consumed.
- sim_end  out  1  sticky halt flag.
- tx_overflow  out  1  sticky; an I/O write was dropped.

Behaviour:
- Reset (async, immediate): data_out=0, FIFO rd/wr pointers and count=0, io_tx_valid=0, io_buffer_full=0, io_rx_ack=0, sim_end=0, tx_overflow=0. RAM contents are not reset. Reset mid-burst discards queued TX bytes.
- rdy_in=0: no RAM write, no FIFO push/pop, data_out/flags hold, io_rx_ack=0.
- Decode: addr_in==IO_PORT_ADDR is IO; addr_in==IO_HALT_ADDR is HALT; everything else is RAM at index addr_in[ADDR_WIDTH-1:0] (upper bits ignored, wrap-around).
- RAM read (wr_en_in=0): data_out <= mem[idx] at the next edge. Latency is exactly 1 cycle: the byte for the address presented in cycle N is valid in cycle N+1.
- RAM write: mem[idx] <= data_in at the edge. A read of the same address in the following cycle returns the new byte.
- IO read: if io_rx_valid, data_out <= io_rx_data and io_rx_ack pulses for one cycle; otherwise data_out <= 0 and no ack.
- IO write: push data_in into the TX FIFO if count<FIFO_DEPTH; if the FIFO is full, drop the byte and set tx_overflow.
- HALT write: sim_end <= 1 (sticky until reset). HALT read returns 0.
- TX FIFO:
  - io_tx_data = mem_fifo[rd_ptr]; io_tx_valid = (count!=0).
  - Pop when io_tx_valid && io_tx_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance. A push into a full FIFO is allowed only if a pop occurs in that same cycle.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
- io_buffer_full is registered: asserted when next_count >= FIFO_DEPTH-1. The one-entry margin covers the controller's one-cycle reaction delay, so a single in-flight I/O write never overflows.
- The controller holds address/data while io_buffer_full=1. A held I/O write produces no push until io_buffer_full deasserts. Repeated identical IO writes on consecutive cycles with io_buffer_full=0 are distinct pushes; the controller guarantees single-cycle presentation.

Test Plan:
- Write 0xAA,0xBB,0xCC,0xDD to 0x100..0x103, then read 0x100..0x103 back-to-back -> data_out = AA,BB,CC,DD, each one cycle after its address.
- Write 0x5A to 0x00020010 with ADDR_WIDTH=17 -> read of 0x00000010 returns 0x5A (address wrap).
- io_tx_ready=0, eight IO writes 0x41..0x48 -> io_buffer_full rises after the 7th push. If an 8th write is forced, the FIFO holds 8 entries; a 9th write sets tx_overflow=1 and count stays 8. Then io_tx_ready=1 -> 0x41..0x48 drain in order and io_buffer_full falls.
- FIFO count=3, push and pop in the same cycle -> count stays 3 and output order is preserved.
- IO read with io_rx_valid=1, io_rx_data=0x31 -> data_out=0x31 next cycle and a one-cycle io_rx_ack. IO read with io_rx_valid=0 -> data_out=0x00, no ack.
- Write to 0x30004 -> sim_end=1. Assert rst_in mid-cycle while 3 bytes are queued -> io_tx_valid and sim_end drop immediately, without waiting for a clock edge.
